// File: rtl/gfx_pkg.sv
// Shared types and width helpers for the glyph blitter: raster modes, FSM
// states and the address-width arithmetic used by the interface and the top.
package gfx_pkg;

    typedef enum logic [1:0] {
        GFX_OR    = 2'd0,
        GFX_CLEAR = 2'd1,
        GFX_XOR   = 2'd2,
        GFX_COPY  = 2'd3
    } gfx_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_ADDR,
        ST_ROW_LATCH,
        ST_PIX_RD,
        ST_PIX_WR,
        ST_DONE
    } gfx_state_e;

    // Counters and addresses never collapse to zero width, even for a 1-wide font.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int font_addr_width(input int nglyph, input int font_h);
        return cnt_width(nglyph * font_h);
    endfunction

    function automatic int fb_addr_width(input int xsize, input int ysize);
        return cnt_width(xsize * ysize / 8);
    endfunction

endpackage

// File: rtl/gfx_glyph_blitter_if.sv
// Request, font ROM and framebuffer signals of the glyph blitter; the blitter
// takes the slave view, the command source / memory side takes the master view.
interface gfx_glyph_blitter_if #(
    parameter int XSIZE  = 128,
    parameter int YSIZE  = 64,
    parameter int FONT_W = 8,
    parameter int FONT_H = 16,
    parameter int NGLYPH = 256
);
    localparam int XW  = gfx_pkg::cnt_width(XSIZE);
    localparam int YW  = gfx_pkg::cnt_width(YSIZE);
    localparam int FAW = gfx_pkg::font_addr_width(NGLYPH, FONT_H);
    localparam int FBW = gfx_pkg::fb_addr_width(XSIZE, YSIZE);

    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_char;
    logic [XW-1:0]     req_x;
    logic [YW-1:0]     req_y;
    logic [1:0]        req_mode;
    logic              req_invert;
    logic              busy;
    logic              done;
    logic [FAW-1:0]    font_addr;
    logic [FONT_W-1:0] font_data;
    logic [FBW-1:0]    fb_addr;
    logic              fb_re;
    logic [7:0]        fb_rdata;
    logic              fb_we;
    logic [7:0]        fb_wdata;

    modport master (
        output req_valid, req_char, req_x, req_y, req_mode, req_invert,
               font_data, fb_rdata,
        input  req_ready, busy, done, font_addr, fb_addr, fb_re, fb_we, fb_wdata
    );

    modport slave (
        input  req_valid, req_char, req_x, req_y, req_mode, req_invert,
               font_data, fb_rdata,
        output req_ready, busy, done, font_addr, fb_addr, fb_re, fb_we, fb_wdata
    );

endinterface

// File: rtl/gfx_bit_merge.sv
// Read-modify-write merge of one pixel into a framebuffer byte; every bit
// other than bitpos passes through untouched.
module gfx_bit_merge
    import gfx_pkg::*;
(
    input  logic [7:0] rdata,
    input  logic [2:0] bitpos,
    input  logic       b,
    input  gfx_mode_e  mode,
    output logic [7:0] wdata
);

    always_comb begin
        wdata = rdata;
        case (mode)
            GFX_OR:    wdata[bitpos] = rdata[bitpos] | b;
            GFX_CLEAR: wdata[bitpos] = rdata[bitpos] & ~b;
            GFX_XOR:   wdata[bitpos] = rdata[bitpos] ^ b;
            GFX_COPY:  wdata[bitpos] = b;
            default:   wdata = rdata;
        endcase
    end

endmodule

// File: rtl/gfx_glyph_blitter.sv
// Draws one font glyph into the page-organised SSD1306 framebuffer at (x, y),
// one pixel per read-modify-write, with clipping and fixed per-glyph timing.
module gfx_glyph_blitter
    import gfx_pkg::*;
#(
    parameter int XSIZE  = 128,
    parameter int YSIZE  = 64,
    parameter int FONT_W = 8,
    parameter int FONT_H = 16,
    parameter int NGLYPH = 256
) (
    input  logic               clk,
    input  logic               reset,
    gfx_glyph_blitter_if.slave bus
);

    localparam int XW  = cnt_width(XSIZE);
    localparam int YW  = cnt_width(YSIZE);
    localparam int FAW = font_addr_width(NGLYPH, FONT_H);
    localparam int FBW = fb_addr_width(XSIZE, YSIZE);
    localparam int CW  = cnt_width(FONT_W);
    localparam int RW  = cnt_width(FONT_H);

    gfx_state_e        state;
    gfx_state_e        state_n;
    logic [7:0]        char_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    gfx_mode_e         mode_q;
    logic              inv_q;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [FONT_W-1:0] font_sh;
    logic              clip_q;

    logic [XW:0]       px;
    logic [YW:0]       py;
    logic              in_bounds;
    logic              last_col;
    logic              last_row;
    logic              pix_bit;
    logic [FBW-1:0]    pix_addr;
    logic [FAW-1:0]    row_addr;
    logic [7:0]        merged;

    logic              ready_c;
    logic              busy_c;
    logic              done_c;
    logic [FAW-1:0]    font_addr_c;
    logic [FBW-1:0]    fb_addr_c;
    logic              fb_re_c;
    logic              fb_we_c;
    logic [7:0]        fb_wdata_c;

    // One extra bit on px/py so coordinates past the display edge are visible for clipping.
    assign px        = {1'b0, x_q} + (XW+1)'(col);
    assign py        = {1'b0, y_q} + (YW+1)'(row);
    assign in_bounds = (32'(px) < XSIZE) && (32'(py) < YSIZE);
    assign pix_addr  = FBW'(32'(py >> 3) * 32'(XSIZE) + 32'(px));
    assign row_addr  = FAW'(32'(char_q) * 32'(FONT_H) + 32'(row));
    assign last_col  = (32'(col) == FONT_W - 1);
    assign last_row  = (32'(row) == FONT_H - 1);
    assign pix_bit   = font_sh[FONT_W-1] ^ inv_q;

    gfx_bit_merge u_merge (
        .rdata  (bus.fb_rdata),
        .bitpos (py[2:0]),
        .b      (pix_bit),
        .mode   (mode_q),
        .wdata  (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        ready_c     = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        font_addr_c = '0;
        fb_addr_c   = '0;
        fb_re_c     = 1'b0;
        fb_we_c     = 1'b0;
        fb_wdata_c  = '0;
        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (bus.req_valid) state_n = ST_ROW_ADDR;
            end
            ST_ROW_ADDR: begin
                font_addr_c = row_addr;
                state_n     = ST_ROW_LATCH;
            end
            ST_ROW_LATCH: state_n = ST_PIX_RD;
            ST_PIX_RD: begin
                if (in_bounds) begin
                    fb_addr_c = pix_addr;
                    fb_re_c   = 1'b1;
                end
                state_n = ST_PIX_WR;
            end
            ST_PIX_WR: begin
                if (!clip_q) begin
                    fb_addr_c  = pix_addr;
                    fb_we_c    = 1'b1;
                    fb_wdata_c = merged;
                end
                if (!last_col)     state_n = ST_PIX_RD;
                else if (last_row) state_n = ST_DONE;
                else               state_n = ST_ROW_ADDR;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // The font row is shifted left per column so the current pixel is always the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= GFX_OR;
            inv_q   <= 1'b0;
            row     <= '0;
            col     <= '0;
            font_sh <= '0;
            clip_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        char_q <= bus.req_char;
                        x_q    <= bus.req_x;
                        y_q    <= bus.req_y;
                        mode_q <= gfx_mode_e'(bus.req_mode);
                        inv_q  <= bus.req_invert;
                        row    <= '0;
                    end
                end
                ST_ROW_LATCH: begin
                    font_sh <= bus.font_data;
                    col     <= '0;
                end
                ST_PIX_RD: clip_q <= !in_bounds;
                ST_PIX_WR: begin
                    if (!last_col) begin
                        col     <= col + 1'b1;
                        font_sh <= font_sh << 1;
                    end else if (!last_row) begin
                        row <= row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.font_addr = font_addr_c;
    assign bus.fb_addr   = fb_addr_c;
    assign bus.fb_re     = fb_re_c;
    assign bus.fb_we     = fb_we_c;
    assign bus.fb_wdata  = fb_wdata_c;

endmodule

// File: tb/tb_gfx_glyph_blitter.sv
// Bench for gfx_glyph_blitter: memory models for font ROM and framebuffer, a
// pixel-by-pixel reference renderer, directed and random draws, reset and merge checks.
module tb_gfx_glyph_blitter;
    import gfx_pkg::*;

    localparam int XSIZE       = 128;
    localparam int YSIZE       = 64;
    localparam int FONT_W      = 8;
    localparam int FONT_H      = 16;
    localparam int NGLYPH      = 256;
    localparam int NBYTES      = XSIZE * YSIZE / 8;
    localparam int DRAW_CYCLES = FONT_H * (2 + 2 * FONT_W) + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    gfx_glyph_blitter_if bif ();

    gfx_glyph_blitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    logic [7:0] m_rdata;
    logic [2:0] m_pos;
    logic       m_b;
    gfx_mode_e  m_mode;
    logic [7:0] m_wdata;

    gfx_bit_merge dut_merge (
        .rdata  (m_rdata),
        .bitpos (m_pos),
        .b      (m_b),
        .mode   (m_mode),
        .wdata  (m_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0] font_rom [NGLYPH*FONT_H];
    logic [7:0] fb_mem   [NBYTES];
    logic [7:0] init_img [NBYTES];
    logic [7:0] ref_img  [NBYTES];
    logic       init_req = 1'b0;
    int         wr_count = 0;
    int         done_count = 0;
    int         overlap_count = 0;
    int         checks = 0;
    int         errors = 0;

    // Synchronous font ROM and framebuffer RAM, both with one cycle of read latency.
    always @(posedge clk) begin
        bif.font_data <= font_rom[bif.font_addr];
        if (init_req) begin
            for (int i = 0; i < NBYTES; i++) fb_mem[i] <= init_img[i];
        end else begin
            if (bif.fb_we) begin
                fb_mem[bif.fb_addr] <= bif.fb_wdata;
                wr_count <= wr_count + 1;
            end
            if (bif.fb_re) bif.fb_rdata <= fb_mem[bif.fb_addr];
        end
        if (bif.done) done_count <= done_count + 1;
        if (bif.fb_re && bif.fb_we) overlap_count <= overlap_count + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] merge_model(input logic [7:0] r, input int pos, input int b, input int mode);
        int mask;
        int v;
        mask = 1 << pos;
        v    = int'(r);
        case (mode)
            0:       if (b != 0) v = v | mask;
            1:       if (b != 0) v = v & ~mask;
            2:       if (b != 0) v = v ^ mask;
            default: v = (b != 0) ? (v | mask) : (v & ~mask);
        endcase
        return v[7:0];
    endfunction

    task automatic model_draw(input int ch, input int x, input int y, input int mode, input int inv, output int nwr);
        int fr, px, py, b, idx;
        nwr = 0;
        for (int r = 0; r < FONT_H; r++) begin
            fr = int'(font_rom[ch * FONT_H + r]);
            for (int c = 0; c < FONT_W; c++) begin
                px = x + c;
                py = y + r;
                b  = ((fr >> (FONT_W - 1 - c)) & 1) ^ inv;
                if (px < XSIZE && py < YSIZE) begin
                    idx = (py / 8) * XSIZE + px;
                    ref_img[idx] = merge_model(ref_img[idx], py % 8, b, mode);
                    nwr++;
                end
            end
        end
    endtask

    task automatic init_fb(input bit rand_fill);
        for (int i = 0; i < NBYTES; i++) begin
            init_img[i] = rand_fill ? 8'($urandom) : 8'h00;
            ref_img[i]  = init_img[i];
        end
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    task automatic compare_image(input string tag);
        int diff = 0;
        for (int i = 0; i < NBYTES; i++) if (fb_mem[i] !== ref_img[i]) diff++;
        check_output(tag, diff, 0);
    endtask

    task automatic start_request(input int ch, input int x, input int y, input int mode, input int inv);
        @(negedge clk);
        check_output("ready_before_req", bif.req_ready, 1);
        bif.req_char   = 8'(ch);
        bif.req_x      = 7'(x);
        bif.req_y      = 6'(y);
        bif.req_mode   = 2'(mode);
        bif.req_invert = 1'(inv);
        bif.req_valid  = 1'b1;
    endtask

    task automatic apply_stimulus(input string tag, input int ch, input int x, input int y,
                                  input int mode, input int inv, output int dut_writes);
        int cycles = 0;
        int wr0;
        int nwr;
        bit done_seen = 0;
        wr0 = wr_count;
        start_request(ch, x, y, mode, inv);
        while (!done_seen && cycles < DRAW_CYCLES + 50) begin
            @(negedge clk);
            if (cycles == 0) bif.req_valid = 1'b0;
            cycles++;
            if (bif.done) done_seen = 1;
        end
        check_output({tag, "_done_seen"}, done_seen, 1);
        check_output({tag, "_cycles"}, cycles, DRAW_CYCLES);
        @(negedge clk);
        check_output({tag, "_ready_after"}, bif.req_ready, 1);
        dut_writes = wr_count - wr0;
        model_draw(ch, x, y, mode, inv, nwr);
        check_output({tag, "_writes"}, dut_writes, nwr);
        compare_image({tag, "_image"});
    endtask

    initial begin
        int nw;
        int cycles;
        int d0;
        int diff;
        bit done_seen;

        bif.req_valid  = 1'b0;
        bif.req_char   = '0;
        bif.req_x      = '0;
        bif.req_y      = '0;
        bif.req_mode   = '0;
        bif.req_invert = 1'b0;
        m_rdata = '0;
        m_pos   = '0;
        m_b     = 1'b0;
        m_mode  = GFX_OR;
        for (int i = 0; i < NGLYPH * FONT_H; i++) font_rom[i] = 8'($urandom);
        for (int r = 0; r < FONT_H; r++) font_rom[8'hDB * FONT_H + r] = 8'hFF;

        repeat (3) @(negedge clk);
        check_output("rst_ready", bif.req_ready, 1);
        check_output("rst_busy", bif.busy, 0);
        check_output("rst_done", bif.done, 0);
        check_output("rst_fb_re", bif.fb_re, 0);
        check_output("rst_fb_we", bif.fb_we, 0);
        check_output("rst_font_addr", bif.font_addr, 0);
        check_output("rst_fb_addr", bif.fb_addr, 0);
        check_output("rst_fb_wdata", bif.fb_wdata, 0);
        reset = 1'b0;

        // Bit merge: every mode, bit position and pixel value on 0xA5, then random bytes.
        for (int md = 0; md < 4; md++)
            for (int p = 0; p < 8; p++)
                for (int bb = 0; bb < 2; bb++) begin
                    m_rdata = 8'hA5;
                    m_pos   = 3'(p);
                    m_b     = 1'(bb);
                    m_mode  = gfx_mode_e'(md);
                    #1;
                    check_output("merge_a5", m_wdata, merge_model(8'hA5, p, bb, md));
                end
        for (int k = 0; k < 16; k++) begin
            m_rdata = 8'($urandom);
            m_pos   = 3'($urandom);
            m_b     = 1'($urandom);
            m_mode  = gfx_mode_e'($urandom_range(0, 3));
            #1;
            check_output("merge_rand", m_wdata, merge_model(m_rdata, int'(m_pos), int'(m_b), int'(m_mode)));
        end

        init_fb(0);
        apply_stimulus("solid_00", 8'hDB, 0, 0, 0, 0, nw);
        check_output("solid_00_nwr", nw, 128);
        check_output("solid_00_b0", fb_mem[0], 8'hFF);
        check_output("solid_00_b135", fb_mem[135], 8'hFF);
        check_output("solid_00_b8", fb_mem[8], 8'h00);

        init_fb(0);
        apply_stimulus("solid_03", 8'hDB, 0, 3, 0, 0, nw);
        check_output("solid_03_b0", fb_mem[0], 8'hF8);
        check_output("solid_03_b128", fb_mem[128], 8'hFF);
        check_output("solid_03_b263", fb_mem[263], 8'h07);
        check_output("solid_03_b264", fb_mem[264], 8'h00);

        init_fb(0);
        apply_stimulus("corner", 8'hDB, 124, 56, 0, 0, nw);
        check_output("corner_nwr", nw, 32);
        check_output("corner_b1020", fb_mem[1020], 8'hFF);
        check_output("corner_b1019", fb_mem[1019], 8'h00);

        init_fb(1);
        apply_stimulus("xor_a", 8'h41, 10, 5, 2, 0, nw);
        apply_stimulus("xor_b", 8'h41, 10, 5, 2, 0, nw);
        diff = 0;
        for (int i = 0; i < NBYTES; i++) if (fb_mem[i] !== init_img[i]) diff++;
        check_output("xor_restore", diff, 0);

        apply_stimulus("copy_inv", 8'hDB, 40, 20, 3, 1, nw);
        check_output("copy_inv_b424", fb_mem[3 * XSIZE + 40], 8'h00);

        for (int k = 0; k < 6; k++)
            apply_stimulus("random", $urandom_range(0, 255), $urandom_range(0, XSIZE - 1),
                           $urandom_range(0, YSIZE - 1), $urandom_range(0, 3), $urandom_range(0, 1), nw);

        // A second request held during the draw must be ignored entirely.
        init_fb(0);
        d0 = done_count;
        start_request(8'hDB, 20, 10, 0, 0);
        cycles = 0;
        done_seen = 0;
        while (!done_seen && cycles < DRAW_CYCLES + 50) begin
            @(negedge clk);
            if (cycles == 0) bif.req_valid = 1'b0;
            if (cycles == 5) begin
                bif.req_char  = 8'h41;
                bif.req_x     = 7'd0;
                bif.req_y     = 6'd0;
                bif.req_mode  = 2'd3;
                bif.req_valid = 1'b1;
            end
            if (cycles == 100) bif.req_valid = 1'b0;
            cycles++;
            if (bif.done) done_seen = 1;
        end
        check_output("busy_done_seen", done_seen, 1);
        check_output("busy_cycles", cycles, DRAW_CYCLES);
        repeat (5) @(negedge clk);
        check_output("busy_done_pulses", done_count - d0, 1);
        check_output("busy_idle", bif.busy, 0);
        model_draw(8'hDB, 20, 10, 0, 0, nw);
        compare_image("busy_image");

        // Reset in the middle of a draw, landing on a pixel write cycle.
        init_fb(0);
        start_request(8'hDB, 0, 0, 3, 0);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) bif.req_valid = 1'b0;
        end
        check_output("midrst_we_before", bif.fb_we, 1);
        d0 = done_count;
        reset = 1'b1;
        #1;
        check_output("midrst_we", bif.fb_we, 0);
        check_output("midrst_re", bif.fb_re, 0);
        check_output("midrst_ready", bif.req_ready, 1);
        check_output("midrst_busy", bif.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_output("midrst_no_done", done_count - d0, 0);

        init_fb(1);
        apply_stimulus("post_rst", $urandom_range(0, 255), $urandom_range(0, XSIZE - 1),
                       $urandom_range(0, YSIZE - 1), $urandom_range(0, 3), $urandom_range(0, 1), nw);

        check_output("re_we_exclusive", overlap_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gfx_glyph_blitter.md
Name: gfx_glyph_blitter

Overview:
Parametrised successor to the fixed 8x16 character-cell renderer: draws one glyph from an external font ROM into the SSD1306 page-organised framebuffer at any pixel position (x, y).
- Supports four raster modes, glyph inversion, configurable font size, and clipping at the display edge.
- Sits between the command source and the framebuffer RAM; the SSD1306 readout path arbitrates RAM access outside this block.

Parameters:
XSIZE, 128, display width in pixels
YSIZE, 64, display height in pixels (multiple of 8)
FONT_W, 8, glyph width in pixels (1..8)
FONT_H, 16, glyph height in rows
NGLYPH, 256, glyphs in font ROM

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  draw request valid
req_ready  out  1  block can accept a request
req_char  in  8  glyph code
req_x  in  $clog2(XSIZE)  left pixel column
req_y  in  $clog2(YSIZE)  top pixel row
req_mode  in  2  0=OR, 1=CLEAR, 2=XOR, 3=COPY
req_invert  in  1  invert glyph bits before raster op
busy  out  1  draw in progress
done  out  1  one-cycle pulse, draw complete
font_addr  out  $clog2(NGLYPH*FONT_H)  font row address = char*FONT_H + row
font_data  in  FONT_W  font row; MSB = leftmost column; valid 1 cycle after font_addr
fb_addr  out  $clog2(XSIZE*YSIZE/8)  byte address = (py>>3)*XSIZE + px
fb_re  out  1  framebuffer read strobe
fb_rdata  in  8  read data, valid 1 cycle after fb_re
fb_we  out  1  framebuffer write strobe
fb_wdata  out  8  write data; bit (py&7) is the pixel

Behaviour:
- Reset (async, any state): state IDLE; req_ready=1; busy=0; done=0; fb_re=0; fb_we=0; font_addr=0; fb_addr=0; fb_wdata=0. A partially drawn glyph stays in the RAM.
- Accept: req_valid & req_ready on a clk edge latches char, x, y, mode and invert. Requests are ignored while busy (req_ready=0).
- FSM:
  - IDLE -> ROW_ADDR on accept.
  - ROW_ADDR: drive font_addr; -> ROW_LATCH.
  - ROW_LATCH: latch font_data; col=0; -> PIX_RD.
  - PIX_RD: compute px=x+col and py=y+row in widths +1 bit. If px<XSIZE and py<YSIZE, drive fb_addr and assert fb_re; otherwise mark the pixel clipped. -> PIX_WR.
  - PIX_WR: if not clipped, fb_we=1 and fb_wdata=merge(fb_rdata, bit). If col==FONT_W-1: if row==FONT_H-1 -> DONE, else row++ and -> ROW_ADDR. Otherwise col++ and -> PIX_RD.
  - DONE: done=1 for one cycle; -> IDLE.
- Pixel bit b = font_row[FONT_W-1-col] ^ invert. Merge on the target bit (py&7); all other bits pass through unchanged:
  - OR: bit |= b
  - CLEAR: bit &= ~b
  - XOR: bit ^= b
  - COPY: bit = b
- Timing is fixed regardless of clipping: 2 cycles per row plus 2 per pixel. done asserts FONT_H*(2+2*FONT_W)+1 cycles after accept (289 for 8x16). req_ready returns high the cycle after done.
- Read-after-write: the write to a byte completes before the next read is issued, so vertically adjacent pixels in the same byte merge correctly with a 1-cycle synchronous RAM.
- busy = (state != IDLE). fb_re and fb_we are never high in the same cycle.
- Coordinates are unsigned. A glyph fully off-screen completes with zero writes.

Decomposition:
- Package gfx_pkg: mode constants (GFX_OR, GFX_CLEAR, GFX_XOR, GFX_COPY), FSM state encoding, address-width helper functions.
- Sub-module gfx_bit_merge: combinational (rdata, bitpos, b, mode) -> wdata. Tested standalone.

Test Plan:
- Solid glyph 0xDB (all rows 0xFF), OR, (0,0), fb zeroed -> bytes 0..7 = 0xFF and 128..135 = 0xFF; 128 writes; done at cycle 289.
- Same glyph at (0,3) -> bytes 0..7 = 0xF8, 128..135 = 0xFF, 256..263 = 0x07; no other bytes change.
- Glyph at (124,56) -> writes only to cols 124..127 of page 7 (bytes 1020..1023 = 0xFF); 32 writes total; done still at cycle 289.
- XOR glyph 0x41 at (10,5) twice on random fb -> fb identical to the initial image; COPY with invert=1 of 0xDB -> covered pixels cleared.
- Assert reset at cycle 50 of a draw -> fb_we=0 immediately, req_ready=1; a request driven while busy is never accepted (no extra done pulse).
- gfx_bit_merge exhaustive sweep of all modes × bitpos × b on rdata 0xA5 -> matches the reference expression.
